// File: rtl/char_lcd_pkg.sv
// Shared constants, bus payload type and transaction decoder for the HD44780 character LCD controller.
// Optional build macro: CHAR_LCD_CURSOR_EN selects the cursor-on/blink display command.
package char_lcd_pkg;

    localparam int unsigned CNT_W  = 9;
    localparam int unsigned T_W    = 7;
    localparam int unsigned DB_W   = 8;
    localparam int unsigned DATA_W = 256;

    localparam logic [DB_W-1:0] CMD_FUNC_SET = 8'h38;
    localparam logic [DB_W-1:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [DB_W-1:0] CMD_DISP_CUR = 8'h0F;
    localparam logic [DB_W-1:0] CMD_ENTRY    = 8'h06;
    localparam logic [DB_W-1:0] CMD_LINE1    = 8'h80;
    localparam logic [DB_W-1:0] CMD_LINE2    = 8'hC0;

`ifdef CHAR_LCD_CURSOR_EN
    localparam logic [DB_W-1:0] CMD_T2 = CMD_DISP_CUR;
`else
    localparam logic [DB_W-1:0] CMD_T2 = CMD_DISP_ON;
`endif

    localparam logic [T_W-1:0] T_LINE1 = 7'd4;
    localparam logic [T_W-1:0] T_LINE2 = 7'd21;
    localparam logic [T_W-1:0] T_IDLE  = 7'd38;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_E_HI0 = 2'd1,
        PH_E_HI1 = 2'd2,
        PH_HOLD  = 2'd3
    } phase_t;

    typedef struct packed {
        logic            rs;
        logic [DB_W-1:0] db;
    } lcd_bus_t;

    // Maps a transaction index to the register-select / data-bus pair it drives.
    function automatic lcd_bus_t decode_txn(input logic [T_W-1:0] t, input logic [DATA_W-1:0] d);
        lcd_bus_t   bus;
        logic [4:0] idx;
        bus = '{rs: 1'b0, db: 8'h00};
        idx = 5'd0;
        if (t < 7'd2) begin
            bus.db = CMD_FUNC_SET;
        end else if (t == 7'd2) begin
            bus.db = CMD_T2;
        end else if (t == 7'd3) begin
            bus.db = CMD_ENTRY;
        end else if (t == T_LINE1) begin
            bus.db = CMD_LINE1;
        end else if (t < T_LINE2) begin
            idx    = 5'(t - 7'd5);
            bus.rs = 1'b1;
            bus.db = d[{idx, 3'b000} +: 8];
        end else if (t == T_LINE2) begin
            bus.db = CMD_LINE2;
        end else if (t < T_IDLE) begin
            idx    = 5'(t - 7'd6);
            bus.rs = 1'b1;
            bus.db = d[{idx, 3'b000} +: 8];
        end
        return bus;
    endfunction

endpackage

// File: rtl/char_lcd_tick_div.sv
// Prescaler: one-clock tick every DIV clocks, counting 0..DIV-1.
module char_lcd_tick_div #(
    parameter int unsigned DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/char_lcd_ctrl.sv
// HD44780 16x2 write-only controller: step counter plus decoder driving registered LCD pins.
// Optional build macro: CHAR_LCD_CURSOR_EN (see char_lcd_pkg).
module char_lcd_ctrl
    import char_lcd_pkg::*;
#(
    parameter int unsigned DIV = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] char_data,
    output logic              lcd_e,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic [DB_W-1:0]   lcd_db
);

    logic             w_tick;
    logic [CNT_W-1:0] r_lcd_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [T_W-1:0]   w_t_next;
    phase_t           w_p_next;
    lcd_bus_t         w_bus_next;
    logic             w_load;
    logic             w_e_next;

    char_lcd_tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    assign w_cnt_next = r_lcd_cnt + 9'd1;
    assign w_t_next   = w_cnt_next[8:2];
    assign w_p_next   = phase_t'(w_cnt_next[1:0]);
    assign w_bus_next = decode_txn(w_t_next, char_data);
    assign w_e_next   = ((w_p_next == PH_E_HI0) || (w_p_next == PH_E_HI1)) && (w_t_next < T_IDLE);

    // Bus loads at the start of each transaction; step 1 also loads so the
    // first transaction after reset carries its command (T0 is a constant).
    assign w_load = (w_p_next == PH_SETUP) || (w_cnt_next == 9'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lcd_cnt <= '0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_db    <= '0;
        end else begin
            lcd_rw <= 1'b0;
            if (w_tick) begin
                r_lcd_cnt <= w_cnt_next;
                lcd_e     <= w_e_next;
                if (w_load) begin
                    lcd_rs <= w_bus_next.rs;
                    lcd_db <= w_bus_next.db;
                end
            end
        end
    end

endmodule

// File: tb/tb_char_lcd_ctrl.sv
// Self-checking bench for char_lcd_ctrl at DIV=4: timed vector table plus a pulse scoreboard.
module tb_char_lcd_ctrl;

    localparam int unsigned DIV = 4;
`ifdef CHAR_LCD_CURSOR_EN
    localparam logic [7:0] EXP_T2 = 8'h0F;
`else
    localparam logic [7:0] EXP_T2 = 8'h0C;
`endif

    typedef struct {
        int         cyc;
        logic       e;
        logic       rs;
        logic [7:0] db;
    } vec_t;

    typedef struct {
        logic       rs;
        logic [7:0] db;
    } txn_t;

    logic         clk;
    logic         reset;
    logic [255:0] char_data;
    logic         lcd_e;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_db;

    int   cyc;
    int   n_cmp;
    int   n_err;
    logic mon_en;
    txn_t sb[$];
    vec_t tbl[16];

    char_lcd_ctrl #(.DIV(DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .char_data (char_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_db    (lcd_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks elapsed since reset release; step k lands at cyc = k*DIV.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic e, input logic rs, input logic [7:0] db);
        chk({name, ".e"},  32'(lcd_e),  32'(e));
        chk({name, ".rs"}, 32'(lcd_rs), 32'(rs));
        chk({name, ".rw"}, 32'(lcd_rw), 32'd0);
        chk({name, ".db"}, 32'(lcd_db), 32'(db));
    endtask

    task automatic wait_cyc(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 10000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 10000) chk("wait_timeout", 32'(cyc), 32'(k));
    endtask

    task automatic push_frame(input logic [255:0] d);
        sb.push_back('{1'b0, 8'h38});
        sb.push_back('{1'b0, 8'h38});
        sb.push_back('{1'b0, EXP_T2});
        sb.push_back('{1'b0, 8'h06});
        sb.push_back('{1'b0, 8'h80});
        for (int n = 0; n < 16; n++) sb.push_back('{1'b1, d[8*n +: 8]});
        sb.push_back('{1'b0, 8'hC0});
        for (int n = 16; n < 32; n++) sb.push_back('{1'b1, d[8*n +: 8]});
    endtask

    // Pops one expected transaction per completed lcd_e pulse.
    task automatic monitor();
        logic prev_e;
        int   hi;
        txn_t t;
        prev_e = 1'b0;
        hi     = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || reset) begin
                prev_e = 1'b0;
                hi     = 0;
            end else begin
                if (lcd_rw !== 1'b0) chk("rw_low", 32'(lcd_rw), 32'd0);
                if (lcd_e === 1'b1) begin
                    if (!prev_e && sb.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
                    hi++;
                end else if (prev_e) begin
                    chk("pulse_width", 32'(hi), 32'(2 * DIV));
                    if (sb.size() > 0) begin
                        t = sb.pop_front();
                        chk("sb_rs", 32'(lcd_rs), 32'(t.rs));
                        chk("sb_db", 32'(lcd_db), 32'(t.db));
                    end
                    hi = 0;
                end
                prev_e = lcd_e;
            end
        end
    endtask

    task automatic apply_vec(input int i);
        wait_cyc(tbl[i].cyc);
        chk_out($sformatf("vec%0d", i), tbl[i].e, tbl[i].rs, tbl[i].db);
    endtask

    logic [255:0] data_a;
    logic [255:0] data_b;

    initial begin
        tbl[0]  = '{3,    1'b0, 1'b0, 8'h00};
        tbl[1]  = '{4,    1'b1, 1'b0, 8'h38};
        tbl[2]  = '{12,   1'b0, 1'b0, 8'h38};
        tbl[3]  = '{16,   1'b0, 1'b0, 8'h38};
        tbl[4]  = '{40,   1'b1, 1'b0, EXP_T2};
        tbl[5]  = '{48,   1'b0, 1'b0, 8'h06};
        tbl[6]  = '{64,   1'b0, 1'b0, 8'h80};
        tbl[7]  = '{84,   1'b1, 1'b1, 8'h41};
        tbl[8]  = '{336,  1'b0, 1'b0, 8'hC0};
        tbl[9]  = '{356,  1'b1, 1'b1, 8'h51};
        tbl[10] = '{600,  1'b1, 1'b1, 8'h60};
        tbl[11] = '{608,  1'b0, 1'b0, 8'h00};
        tbl[12] = '{612,  1'b0, 1'b0, 8'h00};
        tbl[13] = '{2044, 1'b0, 1'b0, 8'h00};
        tbl[14] = '{2048, 1'b0, 1'b0, 8'h38};
        tbl[15] = '{2052, 1'b1, 1'b0, 8'h38};

        for (int n = 0; n < 32; n++) data_a[8*n +: 8] = 8'(8'h41 + n);
        data_b           = data_a;
        data_b[47:40]    = 8'h7A;

        n_cmp     = 0;
        n_err     = 0;
        mon_en    = 1'b0;
        reset     = 1'b1;
        char_data = data_a;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk_out("in_reset", 1'b0, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk_out("in_reset_end", 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        push_frame(data_a);
        mon_en = 1'b1;

        for (int i = 0; i <= 12; i++) apply_vec(i);
        chk("frame1_pulses_left", 32'(sb.size()), 32'd0);
        push_frame(data_a);
        for (int i = 13; i <= 15; i++) apply_vec(i);

        // Frame 2: change byte 5 while T10 is already on the bus.
        wait_cyc(2048 + 41 * DIV);
        chk_out("t10_p1", 1'b1, 1'b1, 8'h46);
        char_data = data_b;
        wait_cyc(2048 + 42 * DIV);
        chk_out("t10_p2_held", 1'b1, 1'b1, 8'h46);
        wait_cyc(2048 + 43 * DIV);
        chk_out("t10_p3_held", 1'b0, 1'b1, 8'h46);
        wait_cyc(2048 + 153 * DIV);
        chk("frame2_pulses_left", 32'(sb.size()), 32'd0);
        push_frame(data_b);

        // Frame 3: new byte visible, then reset in the middle of T12's pulse.
        wait_cyc(4096 + 41 * DIV);
        chk_out("f3_t10", 1'b1, 1'b1, 8'h7A);
        wait_cyc(4096 + 50 * DIV);
        chk_out("f3_t12_p2", 1'b1, 1'b1, 8'h48);
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        chk_out("mid_reset", 1'b0, 1'b0, 8'h00);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        push_frame(data_b);
        mon_en = 1'b1;

        wait_cyc(3);
        chk_out("restart_pre", 1'b0, 1'b0, 8'h00);
        wait_cyc(4);
        chk_out("restart_t0", 1'b1, 1'b0, 8'h38);
        wait_cyc(40);
        chk_out("restart_t2", 1'b1, 1'b0, EXP_T2);
        wait_cyc(612);
        chk("frame4_pulses_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
